// File: rtl/pampy_trace_buffer_pkg.sv
// rtl/pampy_trace_buffer_pkg.sv - shared types and helpers for the pamPy trace buffer
//
// Purpose: FSM state encoding, capture mode constants and the rd_data field
// offset helper used to unpack {pc, instr, arg, tos} entries.
// Ports: none (package).
package pampy_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_CIRC = 1'b1;

  typedef enum logic [1:0] {
    FLD_PC    = 2'd0,
    FLD_INSTR = 2'd1,
    FLD_ARG   = 2'd2,
    FLD_TOS   = 2'd3
  } field_e;

  // LSB position of a field inside an entry; tos sits at bit 0, pc on top.
  function automatic int field_lsb(input field_e f, input int data_w);
    case (f)
      FLD_PC:    return 3 * data_w;
      FLD_INSTR: return 2 * data_w;
      FLD_ARG:   return data_w;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/pampy_trace_buffer_if.sv
// rtl/pampy_trace_buffer_if.sv - observation bus and drain port of the trace buffer
//
// Purpose: groups the core observation samples and the valid/ready read port.
// Ports (signals):
//   cap_en, pc_in, instr_in, arg_in, tos_in : sample from the core side
//   rd_valid, rd_data                       : drained entry from the buffer
//   rd_ready                                : consumer accept
// Modports: master = core/consumer side, slave = trace buffer.
interface pampy_trace_buffer_if #(
  parameter int PC_W   = 12,
  parameter int DATA_W = 8
);
  logic                      cap_en;
  logic [PC_W-1:0]           pc_in;
  logic [DATA_W-1:0]         instr_in;
  logic [DATA_W-1:0]         arg_in;
  logic [DATA_W-1:0]         tos_in;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [PC_W+3*DATA_W-1:0]  rd_data;

  modport master (
    output cap_en, pc_in, instr_in, arg_in, tos_in, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  cap_en, pc_in, instr_in, arg_in, tos_in, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/pampy_trace_buffer_ram.sv
// rtl/pampy_trace_buffer_ram.sv - trace entry storage
//
// Purpose: DEPTH x WIDTH array, one synchronous write port, one combinational
// read port. Contents are not reset.
// Ports:
//   clk           : write clock
//   we/waddr/wdata: write port
//   raddr/rdata   : asynchronous read port
module pampy_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pampy_trace_buffer.sv
// rtl/pampy_trace_buffer.sv - execution-trace capture buffer for the pamPy core
//
// Purpose: captures {pc, instr, arg, tos} samples in fill-once or circular
// (PC-triggered) mode, then drains them oldest-first over a valid/ready port.
// Ports:
//   general_clk, general_reset : clock, async active-low reset
//   arm, clear, mode           : start capture, abort, capture mode (sampled at arm)
//   trig_pc, post_cnt          : trigger address and post-trigger entries (sampled at arm)
//   count, state, wrapped      : status
//   bus (slave)                : observation samples in, drained entries out
module pampy_trace_buffer
  import pampy_trace_pkg::*;
#(
  parameter int PC_W   = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int POST_W = 4
) (
  input  logic                     general_clk,
  input  logic                     general_reset,
  input  logic                     arm,
  input  logic                     clear,
  input  logic                     mode,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic [POST_W-1:0]        post_cnt,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     wrapped,
  pampy_trace_buffer_if.slave      bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int W     = PC_W + 3 * DATA_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_e              st;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [POST_W-1:0]   post_left;
  logic [POST_W-1:0]   post_cfg;
  logic [PC_W-1:0]     trig_q;
  logic                mode_q;
  logic                rd_valid_q;

  logic                we;
  logic [W-1:0]        wdata;
  logic [W-1:0]        ram_rdata;
  logic [PTR_W-1:0]    wr_ptr_inc;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    cnt_dec;
  logic [PTR_W-1:0]    rd_start;
  logic                trig_hit;
  logic                rd_fire;

  assign we         = bus.cap_en && (st == ST_CAPTURE || st == ST_POST);
  assign wdata      = {bus.pc_in, bus.instr_in, bus.arg_in, bus.tos_in};
  assign wr_ptr_inc = wr_ptr + PTR_W'(1);
  assign cnt_inc    = (count == FULL) ? count : count + CNT_W'(1);
  assign cnt_dec    = count - CNT_W'(1);
  assign trig_hit   = (bus.pc_in == trig_q);
  assign rd_fire    = rd_valid_q && bus.rd_ready;

  // Oldest entry after the write that ends capture. When the buffer is full
  // the low bits of the count are zero, so this lands on the write pointer.
  assign rd_start   = wr_ptr_inc - cnt_inc[PTR_W-1:0];

  pampy_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_ram (
    .clk   (general_clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge general_clk or negedge general_reset) begin
    if (!general_reset) begin
      st         <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_left  <= '0;
      post_cfg   <= '0;
      trig_q     <= '0;
      mode_q     <= MODE_FILL;
      rd_valid_q <= 1'b0;
      wrapped    <= 1'b0;
    end else if (clear) begin
      st         <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_left  <= '0;
      rd_valid_q <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (arm) begin
            mode_q   <= mode;
            trig_q   <= trig_pc;
            post_cfg <= post_cnt;
            count    <= '0;
            wr_ptr   <= '0;
            wrapped  <= 1'b0;
            st       <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (bus.cap_en) begin
            wr_ptr <= wr_ptr_inc;
            count  <= cnt_inc;
            // Only circular mode can write while already full.
            if (count == FULL) wrapped <= 1'b1;
            if (mode_q == MODE_FILL) begin
              if (cnt_inc == FULL) begin
                st         <= ST_DRAIN;
                rd_ptr     <= rd_start;
                rd_valid_q <= 1'b1;
              end
            end else if (trig_hit) begin
              post_left <= post_cfg;
              if (post_cfg == '0) begin
                st         <= ST_DRAIN;
                rd_ptr     <= rd_start;
                rd_valid_q <= 1'b1;
              end else begin
                st <= ST_POST;
              end
            end
          end
        end

        ST_POST: begin
          if (bus.cap_en) begin
            wr_ptr    <= wr_ptr_inc;
            count     <= cnt_inc;
            post_left <= post_left - POST_W'(1);
            if (count == FULL) wrapped <= 1'b1;
            if (post_left == POST_W'(1)) begin
              st         <= ST_DRAIN;
              rd_ptr     <= rd_start;
              rd_valid_q <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          // rd_valid falls together with the last read; IDLE follows a cycle later.
          if (count == '0) begin
            st <= ST_IDLE;
          end else if (rd_fire) begin
            rd_ptr     <= rd_ptr + PTR_W'(1);
            count      <= cnt_dec;
            rd_valid_q <= (cnt_dec != '0);
          end
        end

        default: st <= ST_IDLE;
      endcase
    end
  end

  assign state        = st;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_pampy_trace_buffer.sv
// tb/tb_pampy_trace_buffer.sv - self-checking bench for pampy_trace_buffer
module tb_pampy_trace_buffer;
  import pampy_trace_pkg::*;

  localparam int PC_W   = 12;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int POST_W = 4;
  localparam int W      = PC_W + 3 * DATA_W;

  logic              clk = 1'b0;
  logic              general_reset;
  logic              arm, clear, mode;
  logic [PC_W-1:0]   trig_pc;
  logic [POST_W-1:0] post_cnt;
  logic [3:0]        count;
  logic [1:0]        state;
  logic              wrapped;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]    exp_q[$];
  logic [PC_W-1:0] gap_pc [0:8];
  bit              gap_en [0:8];

  pampy_trace_buffer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

  pampy_trace_buffer #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .POST_W (POST_W)
  ) dut (
    .general_clk   (clk),
    .general_reset (general_reset),
    .arm           (arm),
    .clear         (clear),
    .mode          (mode),
    .trig_pc       (trig_pc),
    .post_cnt      (post_cnt),
    .count         (count),
    .state         (state),
    .wrapped       (wrapped),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [PC_W-1:0] pc);
    logic [7:0] lo;
    lo = pc[7:0];
    return {pc, lo ^ 8'h5A, lo + 8'd1, ~lo};
  endfunction

  task automatic cap(input logic [PC_W-1:0] pc, input bit en);
    logic [W-1:0] e;
    e = mk(pc);
    bus.pc_in    = pc;
    bus.instr_in = e[23:16];
    bus.arg_in   = e[15:8];
    bus.tos_in   = e[7:0];
    bus.cap_en   = en;
    step();
    bus.cap_en   = 1'b0;
  endtask

  task automatic do_arm(input bit m, input logic [PC_W-1:0] tp, input logic [POST_W-1:0] pcnt);
    arm = 1'b1; mode = m; trig_pc = tp; post_cnt = pcnt;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    general_reset = 1'b0;
    step(); step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state act=%0d exp=0", state); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count act=%0d exp=0", count); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid act=%b exp=0", bus.rd_valid); end
    checks++; if (wrapped !== 1'b0) begin failures++; $display("FAIL reset_wrapped act=%b exp=0", wrapped); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL reset_rd_data act=%h exp=0", bus.rd_data); end
    general_reset = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [W-1:0] e;
    int guard;
    do_arm(MODE_FILL, 12'h000, 4'd0);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL fill_armed act=%0d exp=1", state); end
    for (int i = 0; i < 8; i++) begin
      cap(PC_W'(i), 1'b1);
      exp_q.push_back(mk(PC_W'(i)));
    end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL fill_drain_state act=%0d exp=3", state); end
    cap(12'h008, 1'b1);
    cap(12'h009, 1'b1);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count act=%0d exp=8", count); end
    bus.rd_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      if (bus.rd_valid) begin
        checks++; if (count !== 4'(exp_q.size())) begin failures++; $display("FAIL fill_drain_count act=%0d exp=%0d", count, exp_q.size()); end
        e = exp_q.pop_front();
        checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL fill_data act=%h exp=%h pc=%h", bus.rd_data, e, bus.rd_data[field_lsb(FLD_PC, DATA_W) +: PC_W]); end
      end
      step(); guard++;
    end
    checks++; if (guard >= 40) begin failures++; $display("FAIL fill_timeout left=%0d exp=0", exp_q.size()); end
    checks++; if (bus.rd_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL fill_empty act=%b/%0d exp=0/0", bus.rd_valid, count); end
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL fill_idle act=%0d exp=0", state); end
    checks++; if (wrapped !== 1'b0) begin failures++; $display("FAIL fill_wrapped act=%b exp=0", wrapped); end
    bus.rd_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_circular();
    logic [W-1:0] e;
    int guard, post_rem, total;
    bit open, seen;
    do_arm(MODE_CIRC, 12'h020, 4'd2);
    open = 1; seen = 0; post_rem = 0; total = 0;
    for (int p = 'h010; p <= 'h030; p++) begin
      cap(PC_W'(p), 1'b1);
      if (open) begin
        exp_q.push_back(mk(PC_W'(p)));
        total++;
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        if (seen) begin
          post_rem--;
          if (post_rem == 0) open = 0;
        end else if (p == 'h020) begin
          seen = 1; post_rem = 2;
        end
      end
    end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL circ_state act=%0d exp=3", state); end
    checks++; if (count !== 4'(exp_q.size())) begin failures++; $display("FAIL circ_count act=%0d exp=%0d", count, exp_q.size()); end
    checks++; if (wrapped !== (total > DEPTH)) begin failures++; $display("FAIL circ_wrapped act=%b exp=%b", wrapped, total > DEPTH); end
    bus.rd_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      if (bus.rd_valid) begin
        e = exp_q.pop_front();
        checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL circ_data act=%h exp=%h", bus.rd_data, e); end
      end
      step(); guard++;
    end
    checks++; if (guard >= 40) begin failures++; $display("FAIL circ_timeout left=%0d exp=0", exp_q.size()); end
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL circ_idle act=%0d exp=0", state); end
    bus.rd_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e, held;
    bit stalled;
    bit pat [0:3];
    int guard, k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_arm(MODE_FILL, 12'h000, 4'd0);
    for (int i = 0; i < 8; i++) begin
      cap(PC_W'('h100 + 3 * i), 1'b1);
      exp_q.push_back(mk(PC_W'('h100 + 3 * i)));
    end
    stalled = 0; held = '0; guard = 0; k = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      bus.rd_ready = pat[k % 4]; k++;
      if (bus.rd_valid) begin
        if (stalled) begin
          checks++; if (bus.rd_data !== held) begin failures++; $display("FAIL bp_hold act=%h exp=%h", bus.rd_data, held); end
        end
        if (bus.rd_ready) begin
          e = exp_q.pop_front();
          checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL bp_data act=%h exp=%h", bus.rd_data, e); end
        end
        held = bus.rd_data;
        stalled = !bus.rd_ready;
      end
      step(); guard++;
    end
    checks++; if (guard >= 60) begin failures++; $display("FAIL bp_timeout left=%0d exp=0", exp_q.size()); end
    bus.rd_ready = 1'b0;
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL bp_idle act=%0d exp=0", state); end
    exp_q.delete();
  endtask

  task automatic test_gaps();
    logic [W-1:0] e;
    int guard, post_rem;
    bit open, seen;
    gap_pc = '{12'h031, 12'h040, 12'h032, 12'h040, 12'h033, 12'h040, 12'h041, 12'h042, 12'h043};
    gap_en = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1,    1'b1};
    do_arm(MODE_CIRC, 12'h040, 4'd1);
    open = 1; seen = 0; post_rem = 0;
    for (int i = 0; i < 9; i++) begin
      cap(gap_pc[i], gap_en[i]);
      if (open && gap_en[i]) begin
        exp_q.push_back(mk(gap_pc[i]));
        if (seen) begin
          post_rem--;
          if (post_rem == 0) open = 0;
        end else if (gap_pc[i] == 12'h040) begin
          seen = 1; post_rem = 1;
        end
      end
      if (i == 3) begin
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL gap_no_trig act=%0d exp=1", state); end
      end
    end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL gap_state act=%0d exp=3", state); end
    checks++; if (count !== 4'(exp_q.size())) begin failures++; $display("FAIL gap_count act=%0d exp=%0d", count, exp_q.size()); end
    bus.rd_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      if (bus.rd_valid) begin
        e = exp_q.pop_front();
        checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL gap_data act=%h exp=%h", bus.rd_data, e); end
      end
      step(); guard++;
    end
    checks++; if (guard >= 40) begin failures++; $display("FAIL gap_timeout left=%0d exp=0", exp_q.size()); end
    step();
    bus.rd_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_abort();
    logic [W-1:0] e;
    do_arm(MODE_CIRC, 12'h050, 4'd2);
    cap(12'h04E, 1'b1);
    cap(12'h04F, 1'b1);
    cap(12'h050, 1'b1);
    cap(12'h051, 1'b1);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL abort_post act=%0d exp=2", state); end
    clear = 1'b1;
    cap(12'h052, 1'b1);
    clear = 1'b0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL abort_state act=%0d exp=0", state); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL abort_count act=%0d exp=0", count); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL abort_rd_valid act=%b exp=0", bus.rd_valid); end
    clear = 1'b1;
    do_arm(MODE_FILL, 12'h000, 4'd0);
    clear = 1'b0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL clear_arm act=%0d exp=0", state); end
    do_arm(MODE_FILL, 12'h000, 4'd0);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL rearm act=%0d exp=1", state); end
    for (int i = 0; i < 8; i++) begin
      cap(PC_W'('h300 + i), 1'b1);
      exp_q.push_back(mk(PC_W'('h300 + i)));
    end
    checks++; if (state !== 2'd3 || count !== 4'd8) begin failures++; $display("FAIL rearm_full act=%0d/%0d exp=3/8", state, count); end
    e = exp_q.pop_front();
    checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL rearm_data act=%h exp=%h", bus.rd_data, e); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (state !== 2'd0 || count !== 4'd0) begin failures++; $display("FAIL clear_drain act=%0d/%0d exp=0/0", state, count); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] e;
    do_arm(MODE_CIRC, 12'h2F0, 4'd0);
    for (int i = 0; i < 8; i++) cap(PC_W'('h200 + i), 1'b1);
    cap(12'h2F0, 1'b1);
    for (int i = 1; i < 8; i++) exp_q.push_back(mk(PC_W'('h200 + i)));
    exp_q.push_back(mk(12'h2F0));
    checks++; if (state !== 2'd3 || wrapped !== 1'b1) begin failures++; $display("FAIL rst_pre act=%0d/%b exp=3/1", state, wrapped); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL rst_read act=%h exp=%h", bus.rd_data, e); end
      step();
    end
    bus.rd_ready = 1'b0;
    #2 general_reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_async_state act=%0d exp=0", state); end
    checks++; if (count !== 4'd0 || wrapped !== 1'b0) begin failures++; $display("FAIL rst_async_cnt act=%0d/%b exp=0/0", count, wrapped); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin failures++; $display("FAIL rst_async_rd act=%b/%h exp=0/0", bus.rd_valid, bus.rd_data); end
    step();
    general_reset = 1'b1;
    step();
    do_arm(MODE_FILL, 12'h000, 4'd0);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL rst_rearm act=%0d exp=1", state); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    general_reset = 1'b0;
    arm = 1'b0; clear = 1'b0; mode = 1'b0; trig_pc = '0; post_cnt = '0;
    bus.cap_en = 1'b0; bus.pc_in = '0; bus.instr_in = '0; bus.arg_in = '0; bus.tos_in = '0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_fill();
    test_circular();
    test_backpressure();
    test_gaps();
    test_abort();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pampy_trace_buffer.md
Name: pampy_trace_buffer

Overview:
- Parametrised execution-trace capture block for the pamPy stack processor.
- Samples the core's observation bus (PC, instruction, argument, top-of-stack) into an on-chip buffer.
- Supports fill-once and circular-with-PC-trigger modes, then drains the captured entries oldest-first over a valid/ready read port.
- Sits beside the pamPy core. In simulation it replaces ad-hoc waveform probing of GENERAL_PC_OUT / GENERAL_INSTR_OUT / GENERAL_ARG_OUT / TOP_STACK_OUT.

Parameters:
- PC_W, 12, width of PC field.
- DATA_W, 8, width of each of the instr, arg and tos fields.
- DEPTH, 16, number of trace entries. Must be a power of two, at least 2.
- POST_W, 4, width of the post-trigger count input.

Ports:
- general_clk  in  1  single clock; all state on rising edge.
- general_reset  in  1  asynchronous, active-low reset.
- arm  in  1  start-capture pulse; honoured only in IDLE.
- clear  in  1  synchronous abort to IDLE, empties buffer; priority over everything except reset.
- mode  in  1  0 = fill-once, 1 = circular with trigger; sampled at arm.
- cap_en  in  1  qualifies the current sample; capture only when high.
- pc_in  in  PC_W  core PC.
- instr_in  in  DATA_W  core opcode.
- arg_in  in  DATA_W  core argument.
- tos_in  in  DATA_W  core top of stack.
- trig_pc  in  PC_W  trigger address; sampled at arm.
- post_cnt  in  POST_W  entries captured after the trigger entry; sampled at arm.
- rd_valid  out  1  rd_data holds an unread entry.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  PC_W+3*DATA_W  {pc, instr, arg, tos}, MSB first.
- count  out  clog2(DEPTH)+1  entries held, saturating at DEPTH.
- state  out  2  IDLE=0, CAPTURE=1, POST=2, DRAIN=3.
- wrapped  out  1  circular mode overwrote at least one entry.

Behaviour:
- Reset (async, general_reset=0):
  - state IDLE; wr_ptr, rd_ptr, count, post_left = 0.
  - rd_valid=0, wrapped=0, rd_data=0.
  - Buffer contents don't-care. Reset mid-capture or mid-drain discards everything.
- IDLE:
  - arm=1 → CAPTURE next cycle.
  - Latch mode, trig_pc, post_cnt. Clear count, wr_ptr and wrapped.
  - Samples in the arm cycle itself are not captured.
- CAPTURE, every cycle with cap_en=1:
  - Write {pc_in, instr_in, arg_in, tos_in} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH.
- CAPTURE, mode 0:
  - When the write makes count reach DEPTH → DRAIN next cycle.
  - Trigger is ignored.
- CAPTURE, mode 1:
  - Writes past DEPTH overwrite the oldest entry and set wrapped=1.
  - If cap_en=1 and pc_in==trig_pc, the trigger entry is written that cycle and post_left=post_cnt.
  - If post_cnt==0 → DRAIN next cycle; else → POST.
- POST:
  - Each cap_en=1 cycle writes one entry and decrements post_left.
  - The write that takes post_left to 0 → DRAIN next cycle.
  - Further trigger matches are ignored.
- DRAIN:
  - rd_ptr = (wr_ptr - count) mod DEPTH, computed on entry.
  - rd_valid = (count != 0). rd_data = mem[rd_ptr], combinational read.
  - rd_valid and rd_ready in the same cycle → rd_ptr+1 mod DEPTH, count-1.
  - rd_data must stay stable while rd_valid=1 and rd_ready=0.
  - No captures occur in DRAIN.
  - count reaches 0 → IDLE next cycle; rd_valid drops in that same cycle.
  - arm is ignored in DRAIN.
- clear: any state → IDLE next cycle, count=0, rd_valid=0, wrapped=0.
- Simultaneous clear and arm in IDLE: clear wins; no capture is started.
- Pointers are clog2(DEPTH) bits wide and wrap naturally. count is one bit wider so that full (count==DEPTH) differs from empty.

Decomposition:
- Package pampy_trace_pkg holds:
  - the state encoding constants (ST_IDLE..ST_DRAIN);
  - MODE_FILL / MODE_CIRC;
  - an entry-field offset function for unpacking rd_data.
- One sub-module: pampy_trace_ram, a DEPTH x (PC_W+3*DATA_W) array with a single synchronous write port and a combinational read port.
- The FSM, pointers and counters stay in the top module.

Test Plan:
- Fill mode (DEPTH=8): arm with mode=0, then 10 cycles with cap_en=1 and pc_in=0x000..0x009 → state=DRAIN after the 8th write. rd_ready held 1 reads pc 0x000..0x007 in order, count 8→0, then IDLE. wrapped=0.
- Circular trigger: DEPTH=8, trig_pc=0x020, post_cnt=2, pc_in stepping 0x010..0x030 → reads pc 0x01B..0x022 (8 entries) and wrapped=1.
- Backpressure: in DRAIN, toggle rd_ready 1,0,0,1 → rd_data is held through the stall cycles, and no entry is skipped or duplicated.
- Gaps and trigger: in mode 1, cap_en low on alternate cycles with the trigger PC presented while cap_en=0 → no trigger fires. It fires on the next qualified match, and the stored entries are only the qualified samples.
- Abort: clear asserted in POST with post_left=1 → IDLE next cycle, count=0, rd_valid=0. A subsequent arm works normally.
- Reset: general_reset low mid-DRAIN after 3 reads → all outputs are 0 immediately (async), state=IDLE. After release, arm is accepted.
